// File: rtl/reg_fwd_scoreboard_if.sv
// Operand-resolution bus for reg_fwd_scoreboard: register reads, EX/MM/WB
// forwarding paths, long-latency issue/done, and the resolved outputs.
package reg_fwd_pkg;
  localparam logic [1:0] ACCESS_OP_NOP = 2'b00;
  localparam logic [1:0] ACCESS_OP_D2R = 2'b01;
  localparam logic [1:0] ACCESS_OP_M2R = 2'b10;
  localparam logic [1:0] ACCESS_OP_R2M = 2'b11;
endpackage

interface reg_fwd_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int LAT_W  = 4
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rf_val;
  logic [ADDR_W-1:0]        ex_addr;
  logic [DATA_W-1:0]        ex_val;
  logic [1:0]               ex_op;
  logic [ADDR_W-1:0]        mm_addr;
  logic [DATA_W-1:0]        mm_val;
  logic [1:0]               mm_op;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_val;
  logic                     wb_we;
  logic                     iss_valid;
  logic [ADDR_W-1:0]        iss_addr;
  logic [LAT_W-1:0]         iss_lat;
  logic                     done_valid;
  logic [ADDR_W-1:0]        done_addr;
  logic                     flush;
  logic [NUM_RD*DATA_W-1:0] fwd_val_o;
  logic                     stall_o;
  logic                     busy_o;

  modport slave (
    input  rd_addr, rf_val,
    input  ex_addr, ex_val, ex_op,
    input  mm_addr, mm_val, mm_op,
    input  wb_addr, wb_val, wb_we,
    input  iss_valid, iss_addr, iss_lat,
    input  done_valid, done_addr, flush,
    output fwd_val_o, stall_o, busy_o
  );

  modport master (
    output rd_addr, rf_val,
    output ex_addr, ex_val, ex_op,
    output mm_addr, mm_val, mm_op,
    output wb_addr, wb_val, wb_we,
    output iss_valid, iss_addr, iss_lat,
    output done_valid, done_addr, flush,
    input  fwd_val_o, stall_o, busy_o
  );
endinterface

// File: rtl/reg_fwd_scoreboard.sv
// ID-stage operand forwarding with a per-register latency scoreboard.
// Optional stall statistics counter: define FWD_STALL_STAT_EN.
module reg_fwd_scoreboard
  import reg_fwd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int LAT_W  = 4
) (
  input  logic clk,
  input  logic rst_n,
  reg_fwd_scoreboard_if.slave bus
`ifdef FWD_STALL_STAT_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);
  localparam int DEPTH = 2**ADDR_W;

  logic [ADDR_W-1:0]        ra [NUM_RD];
  logic [LAT_W-1:0]         cnt_q [DEPTH];
  logic [LAT_W-1:0]         cnt_d [DEPTH];
  logic                     busy_q;
  logic                     busy_d;
  logic [NUM_RD*DATA_W-1:0] fwd_val;
  logic                     lu_haz;
  logic                     sb_haz;
  logic                     stall;
  logic                     iss_ok;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_ra
    assign ra[g] = bus.rd_addr[g*ADDR_W +: ADDR_W];
  end

  assign iss_ok = bus.iss_valid
                && (bus.iss_addr != '0)
                && (bus.iss_lat != '0);

  always_comb begin
    fwd_val = '0;
    lu_haz  = 1'b0;
    sb_haz  = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (ra[i] == '0)
        fwd_val[i*DATA_W +: DATA_W] = '0;
      else if (ra[i] == bus.ex_addr
               && bus.ex_op == ACCESS_OP_D2R)
        fwd_val[i*DATA_W +: DATA_W] = bus.ex_val;
      else if (ra[i] == bus.mm_addr
               && (bus.mm_op == ACCESS_OP_D2R
                   || bus.mm_op == ACCESS_OP_M2R))
        fwd_val[i*DATA_W +: DATA_W] = bus.mm_val;
      else if (ra[i] == bus.wb_addr && bus.wb_we)
        fwd_val[i*DATA_W +: DATA_W] = bus.wb_val;
      else
        fwd_val[i*DATA_W +: DATA_W] =
          bus.rf_val[i*DATA_W +: DATA_W];
      if (ra[i] != '0 && ra[i] == bus.ex_addr
          && bus.ex_op == ACCESS_OP_M2R)
        lu_haz = 1'b1;
      if (cnt_q[ra[i]] != '0)
        sb_haz = 1'b1;
    end
    // entries are about to be wiped, so they must not hold the stage
    sb_haz = sb_haz && rst_n;
  end

  assign stall         = lu_haz | sb_haz;
  assign bus.fwd_val_o = fwd_val;
  assign bus.stall_o   = stall;
  assign bus.busy_o    = busy_q;

  always_comb begin
    busy_d = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      cnt_d[r] = cnt_q[r];
      if (bus.flush)
        cnt_d[r] = '0;
      else if (iss_ok && bus.iss_addr == ADDR_W'(r))
        cnt_d[r] = bus.iss_lat;
      else if (bus.done_valid
               && bus.done_addr == ADDR_W'(r))
        cnt_d[r] = '0;
      else if (cnt_q[r] != '0)
        cnt_d[r] = cnt_q[r] - 1'b1;
      busy_d = busy_d | (cnt_d[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++)
        cnt_q[r] <= '0;
      busy_q <= 1'b0;
    end else begin
      for (int r = 0; r < DEPTH; r++)
        cnt_q[r] <= cnt_d[r];
      busy_q <= busy_d;
    end
  end

`ifdef FWD_STALL_STAT_EN
  logic [31:0] scnt_q;
  logic [31:0] scnt_d;

  always_comb begin
    scnt_d = scnt_q;
    if (stall && scnt_q != 32'hFFFF_FFFF)
      scnt_d = scnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) scnt_q <= '0;
    else        scnt_q <= scnt_d;
  end

  assign stall_cnt_o = scnt_q;
`endif
endmodule
